// File: rtl/scaler_snapshot.sv
// Per-PPS snapshot of the trigger scaler count: captures COUNT on each PPS rising edge
// (or on a watchdog timeout) and queues {TMO, SEQ, DELTA} in a first-word-fall-through FIFO.
module scaler_snapshot #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TIMEOUT    = 130000000
) (
  input  logic                  CLK120,
  input  logic                  RST_N,
  input  logic                  ENABLE,
  input  logic                  PPS,
  input  logic [31:0]           COUNT,
  input  logic                  RD,
  output logic [47:0]           DOUT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic [DEPTH_LOG2:0]   NENTRIES,
  output logic [15:0]           DROPPED,
  output logic                  BUSY,
  output logic [2:0]            DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_LATCH = 3'd3,
    S_DELTA = 3'd4,
    S_PUSH  = 3'd5
  } state_t;

  localparam int                     DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [31:0]            TMO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [DEPTH_LOG2-1:0]  PTR_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]    CNT_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]    CNT_DEPTH = (DEPTH_LOG2+1)'(DEPTH);

  state_t                 state_q, state_d;
  logic                   pps_prev_q;
  logic [31:0]            prev_q, prev_d;
  logic [31:0]            snap_q, snap_d;
  logic [31:0]            delta_q, delta_d;
  logic                   tmo_q, tmo_d;
  logic [31:0]            timer_q, timer_d;
  logic [14:0]            seq_q, seq_d;
  logic [15:0]            dropped_q, dropped_d;
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    count_q, count_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic [47:0]            mem_q [DEPTH];

  logic                   pps_edge;
  logic                   wr_req;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic [47:0]            wr_data;

  assign pps_edge = PPS & ~pps_prev_q;

  // Each state's register action happens on the edge that enters it, so the
  // entry lands in the FIFO on the third edge after the PPS edge is seen.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    snap_d  = snap_q;
    delta_d = delta_q;
    tmo_d   = tmo_q;
    timer_d = timer_q;
    wr_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ENABLE) begin
          state_d = S_PRIME;
          prev_d  = COUNT;
          timer_d = '0;
        end
      end
      S_PRIME: begin
        timer_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        timer_d = timer_q + 32'd1;
        if (pps_edge || (timer_q == TMO_LAST)) begin
          state_d = S_LATCH;
          tmo_d   = ~pps_edge;
          snap_d  = COUNT;
          timer_d = '0;
        end
      end
      S_LATCH: begin
        timer_d = timer_q + 32'd1;
        delta_d = snap_q - prev_q;
        prev_d  = snap_q;
        state_d = S_DELTA;
      end
      S_DELTA: begin
        timer_d = timer_q + 32'd1;
        wr_req  = 1'b1;
        state_d = S_PUSH;
      end
      S_PUSH: begin
        timer_d = timer_q + 32'd1;
        state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
    // Disable abandons whatever is in flight; re-enable re-primes PREV.
    if (!ENABLE) begin
      state_d = S_IDLE;
      wr_req  = 1'b0;
    end
  end

  assign wr_data = {tmo_q, seq_q, delta_q};
  assign pop     = RD & ~empty_q;
  assign push    = wr_req & (~full_q | pop);
  assign drop    = wr_req & ~push;

  always_comb begin
    wr_ptr_d  = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d    = (count_d == CNT_DEPTH);
    empty_d   = (count_d == '0);
    // SEQ advances on drops too, so lost entries show up as gaps.
    seq_d     = wr_req ? (seq_q + 15'd1) : seq_q;
    dropped_d = (drop && (dropped_q != 16'hFFFF)) ? (dropped_q + 16'd1) : dropped_q;
  end

  always_ff @(posedge CLK120 or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      pps_prev_q <= 1'b0;
      prev_q     <= '0;
      snap_q     <= '0;
      delta_q    <= '0;
      tmo_q      <= 1'b0;
      timer_q    <= '0;
      seq_q      <= '0;
      dropped_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      pps_prev_q <= PPS;
      prev_q     <= prev_d;
      snap_q     <= snap_d;
      delta_q    <= delta_d;
      tmo_q      <= tmo_d;
      timer_q    <= timer_d;
      seq_q      <= seq_d;
      dropped_q  <= dropped_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  always_ff @(posedge CLK120) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Head is forced to zero while empty so DOUT reads 0 out of reset.
  assign DOUT      = empty_q ? 48'd0 : mem_q[rd_ptr_q];
  assign EMPTY     = empty_q;
  assign FULL      = full_q;
  assign NENTRIES  = count_q;
  assign DROPPED   = dropped_q;
  assign BUSY      = (state_q != S_IDLE);
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_scaler_snapshot.sv
// Directed bench for scaler_snapshot: a table of PPS snapshots plus hand-written
// sequences for timeout, FIFO full/drop, disable mid-flight and async reset.
module tb_scaler_snapshot;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        pps;
  logic [31:0] count;
  logic        rd;
  logic [47:0] dout;
  logic        empty;
  logic        full;
  logic [4:0]  nentries;
  logic [15:0] dropped;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  scaler_snapshot #(.DEPTH_LOG2(4), .TIMEOUT(100)) dut (
    .CLK120    (clk),
    .RST_N     (rst_n),
    .ENABLE    (enable),
    .PPS       (pps),
    .COUNT     (count),
    .RD        (rd),
    .DOUT      (dout),
    .EMPTY     (empty),
    .FULL      (full),
    .NENTRIES  (nentries),
    .DROPPED   (dropped),
    .BUSY      (busy),
    .DBG_STATE (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cnt;
    logic [47:0] exp;
  } vec_t;

  function automatic logic [47:0] mk(input logic tmo, input int seq, input logic [31:0] d);
    return {tmo, 15'(seq), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic do_enable(input logic [31:0] c);
    count  = c;
    enable = 1'b1;
    tick();
    tick();
  endtask

  // One PPS pulse with COUNT held; returns with the FSM back in RUN.
  task automatic pulse(input logic [31:0] c, input bit chk);
    int n0;
    n0    = int'(nentries);
    count = c;
    pps   = 1'b1;
    tick();
    pps   = 1'b0;
    tick();
    if (chk) begin
      check("lat_n_before", nentries, 64'(n0));
      if (n0 == 0) check("lat_empty_before", empty, 1);
    end
    tick();
    if (chk) begin
      check("lat_n_after", nentries, 64'(n0 + 1));
      if (n0 == 0) check("lat_empty_after", empty, 0);
    end
    tick();
  endtask

  initial begin
    vec_t tbl[6];
    logic [31:0] cur;
    int t;

    tbl[0] = '{32'd1250,        mk(1'b0, 0, 32'd250)};
    tbl[1] = '{32'hFFFF_FFF0,   mk(1'b0, 1, 32'hFFFF_FB0E)};
    tbl[2] = '{32'h0000_0010,   mk(1'b0, 2, 32'h0000_0020)};
    tbl[3] = '{32'h0000_0010,   mk(1'b0, 3, 32'h0000_0000)};
    tbl[4] = '{32'h1234_5678,   mk(1'b0, 4, 32'h1234_5668)};
    tbl[5] = '{32'h8000_0000,   mk(1'b0, 5, 32'h6DCB_A988)};

    rst_n  = 1'b0;
    enable = 1'b0;
    pps    = 1'b0;
    rd     = 1'b0;
    count  = '0;
    tick();
    tick();
    check("rst_dout", dout, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_n", nentries, 0);
    check("rst_dropped", dropped, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Table of snapshots, including the 32-bit wrap and a zero delta.
    do_enable(32'd1000);
    check("busy_run", busy, 1);
    for (int i = 0; i < 6; i++) begin
      pulse(tbl[i].cnt, 1'b1);
      check("tbl_dout", dout, tbl[i].exp);
      check("tbl_n", nentries, 1);
      pop();
      check("tbl_empty", empty, 1);
    end

    // Watchdog: 102 cycles from RUN entry to the forced entry, then a PPS
    // edge landing exactly on the next expiry must win with TMO=0.
    enable = 1'b0;
    tick();
    check("dis_busy", busy, 0);
    do_enable(32'h100);
    count = 32'h164;
    t = 0;
    while (empty && t < 200) begin
      tick();
      t++;
    end
    check("tmo_latency", t, 102);
    check("tmo_dout", dout, mk(1'b1, 6, 32'h64));
    pop();
    t++;
    while (t < 199) begin
      tick();
      t++;
    end
    pulse(32'h1C8, 1'b1);
    check("tie_dout", dout, mk(1'b0, 7, 32'h64));
    check("tie_n", nentries, 1);
    pop();

    // Overfill: 18 edges, 16 kept, 2 dropped.
    cur = 32'h1C8;
    for (int i = 0; i < 18; i++) begin
      cur = cur + 32'd10;
      pulse(cur, i < 16);
      check("fill_n", nentries, (i < 16) ? 64'(i + 1) : 64'd16);
      check("fill_drop", dropped, (i < 16) ? 64'd0 : 64'(i - 15));
    end
    check("fill_full", full, 1);
    for (int i = 0; i < 16; i++) begin
      check("drain_dout", dout, mk(1'b0, 8 + i, 32'd10));
      pop();
    end
    check("drain_empty", empty, 1);
    check("drain_full", full, 0);
    check("drain_n", nentries, 0);

    // Refill, then a commit coinciding with a pop while full.
    for (int i = 0; i < 16; i++) begin
      cur = cur + 32'd10;
      pulse(cur, 1'b1);
    end
    check("refill_full", full, 1);
    cur   = cur + 32'd10;
    count = cur;
    pps   = 1'b1;
    tick();
    pps   = 1'b0;
    tick();
    rd    = 1'b1;
    tick();
    rd    = 1'b0;
    tick();
    check("fullrd_n", nentries, 16);
    check("fullrd_full", full, 1);
    check("fullrd_drop", dropped, 2);
    check("fullrd_head", dout, mk(1'b0, 27, 32'd10));
    for (int i = 0; i < 16; i++) begin
      check("drain2_dout", dout, mk(1'b0, 27 + i, 32'd10));
      pop();
    end
    check("drain2_empty", empty, 1);

    // Disable while in DELTA: nothing written, SEQ kept, re-prime on enable.
    cur   = cur + 32'd10;
    count = cur;
    pps   = 1'b1;
    tick();
    pps   = 1'b0;
    tick();
    enable = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_n", nentries, 0);
    check("abort_empty", empty, 1);
    do_enable(32'd5000);
    pulse(32'd5007, 1'b1);
    check("reen_dout", dout, mk(1'b0, 43, 32'd7));
    check("reen_drop", dropped, 2);
    pop();

    // Asynchronous reset in PUSH with three entries queued.
    pulse(32'd5010, 1'b1);
    pulse(32'd5020, 1'b1);
    count = 32'd5030;
    pps   = 1'b1;
    tick();
    pps   = 1'b0;
    tick();
    tick();
    check("pre_rst_n", nentries, 3);
    check("pre_rst_busy", busy, 1);
    #1;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("arst_dout", dout, 0);
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    check("arst_n", nentries, 0);
    check("arst_dropped", dropped, 0);
    check("arst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_enable(32'd100);
    pulse(32'd130, 1'b1);
    check("post_rst_dout", dout, mk(1'b0, 0, 32'd30));
    pop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scaler_snapshot.md
Name: scaler_snapshot

Overview:
- Sits directly downstream of the trigger scaler. It consumes the scaler's free-running 32-bit COUNT.
- On each PPS rising edge it captures COUNT and computes the per-interval increment, modulo 2^32.
- It pushes a tagged entry into a small first-word-fall-through FIFO that the PS reads over the register interface.
- A watchdog interval timer forces a snapshot when PPS is missing, so the rate stream never stalls.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 16 entries).
- TIMEOUT, 130000000, CLK120 cycles without PPS before a forced snapshot (~1.083 s).

Ports:
- CLK120 in 1: single clock for all logic.
- RST_N in 1: reset, asynchronous assert, active-low.
- ENABLE in 1: run enable, level, synchronous to CLK120.
- PPS in 1: pulse-per-second, synchronous to CLK120; only the rising edge is used.
- COUNT in 32: scaler running count; wraps 0xFFFFFFFF→0.
- RD in 1: pop strobe; one entry per cycle high.
- DOUT out 48: FIFO head = {TMO[47], SEQ[46:32], DELTA[31:0]}.
- EMPTY out 1: FIFO empty.
- FULL out 1: FIFO holds DEPTH entries.
- NENTRIES out DEPTH_LOG2+1: current occupancy.
- DROPPED out 16: entries lost to a full FIFO; saturating.
- BUSY out 1: FSM not in IDLE.

Behaviour:
- Reset (RST_N low, async) values:
  - Outputs: DOUT=0, EMPTY=1, FULL=0, NENTRIES=0, DROPPED=0, BUSY=0.
  - Internal: FSM=IDLE, SEQ=0, PREV=0, interval timer=0, PPS_D=0.
  - FIFO pointers=0.
- PPS edge detection: PPS_D is registered each cycle. An edge is PPS & !PPS_D.
- FSM states:
  - IDLE: BUSY=0. Leave on ENABLE=1 → PRIME.
  - PRIME (1 cycle): PREV<=COUNT; timer<=0 → RUN.
  - RUN: timer increments each cycle.
    - PPS edge → LATCH with TMO=0.
    - Otherwise, timer==TIMEOUT-1 → LATCH with TMO=1.
    - PPS edge wins if both occur in the same cycle (TMO=0).
  - LATCH (1 cycle): SNAP<=COUNT; timer<=0 → DELTA.
  - DELTA (1 cycle): DELTA<=SNAP-PREV, 32-bit unsigned modulo arithmetic (wrap handled implicitly); PREV<=SNAP → PUSH.
  - PUSH (1 cycle): write {TMO, SEQ, DELTA} if accepted, else DROPPED<=DROPPED+1, saturating at 0xFFFF. SEQ increments by 1 (15-bit wrap) in both cases, so drops appear as SEQ gaps. → RUN.
- Latency:
  - PPS goes high at cycle edge N → PPS edge seen in N → LATCH at N+1 (COUNT sampled at edge N+1).
  - Entry is written at edge N+3; EMPTY falls after edge N+3.
- Timer behaviour: counts during LATCH/DELTA/PUSH are not lost, because the timer restarts at LATCH. PPS edges arriving in LATCH, DELTA or PUSH are ignored.
- ENABLE deassert in any non-IDLE state → IDLE next cycle. Any in-flight entry is abandoned. FIFO contents, SEQ and DROPPED are retained. Re-enable re-primes PREV, so the first delta never spans the disabled gap.
- FIFO:
  - First-word fall-through: DOUT is valid whenever EMPTY=0.
  - RD while EMPTY=1 is ignored; NENTRIES is unchanged.
  - A write is accepted if NENTRIES<DEPTH, or if NENTRIES==DEPTH and RD pops in the same cycle.
  - Simultaneous write and pop leaves NENTRIES unchanged, and DOUT advances to the next entry.
  - FULL = (NENTRIES==DEPTH) and EMPTY = (NENTRIES==0); both are registered and consistent with NENTRIES every cycle.
  - Pointers are DEPTH_LOG2 bits and wrap naturally.
- DROPPED and SEQ are cleared only by RST_N.

Test Plan:
1. Enable with COUNT=1000; PPS edge when COUNT=1250 → one entry DOUT={0, SEQ=0, DELTA=250}; EMPTY falls exactly 3 cycles after the PPS edge.
2. PREV=0xFFFFFFF0, PPS edge with COUNT=0x00000010 → DELTA=0x20 (wrap handled); next edge with COUNT unchanged → DELTA=0, SEQ=1.
3. No PPS for TIMEOUT cycles (override TIMEOUT=100) → entry with TMO=1 at cycle ~103 after PRIME; PPS edge in the same cycle as timer expiry → TMO=0.
4. 18 PPS edges with no RD → NENTRIES=16, FULL=1, DROPPED=2; popping all 16 gives SEQ 0..15. Then PUSH coinciding with RD while full → accepted, NENTRIES stays 16.
5. Deassert ENABLE during DELTA → no entry written, BUSY=0 next cycle, SEQ unchanged. Re-enable at COUNT=5000; PPS edge at COUNT=5007 → DELTA=7.
6. Assert RST_N low mid-PUSH with 3 entries queued → all outputs at reset values immediately (async), SEQ=0 after release.
